// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// The cfg struct is declared inside the top because its field widths follow MAX_LEN.
package seq_det_pkg;

  localparam int SEQ_MAX_LEN = 8;
  localparam int SEQ_CNT_W = 8;
  localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0000_1011;
  localparam int SEQ_DEF_LEN = 4;
  localparam logic SEQ_DEF_OVERLAP = 1'b1;

  // Bits needed to hold a length in the range 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// Sliding history window with fill tracking and masked pattern compare.
// Produces hit combinationally for the bit being sampled on the current edge.
module seq_det_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               restart,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist_reg;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W:0]     len_ext;
  logic               full;
  logic               match;

  assign hist_next = {hist_reg[MAX_LEN-2:0], x};
  assign len_ext   = {1'b0, len};

  // Only the youngest len bits of the window take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (len_ext > (LEN_W+1)'(gi));
    end
  endgenerate

  assign fill_inc = {1'b0, fill_reg} + (LEN_W+1)'(1);
  assign full     = (fill_inc >= len_ext);
  assign match    = (((hist_next ^ pattern) & mask) == '0);
  assign hit      = step && full && match;

  // Non-overlap mode restarts the fill so bits of a match cannot seed the next one.
  always_comb begin
    fill_next = fill_reg;
    if (hit && !overlap) begin
      fill_next = '0;
    end else if (fill_inc > len_ext) begin
      fill_next = len;
    end else begin
      fill_next = fill_inc[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (restart) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (step) begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector: config registers, error flag,
// registered match pulse and saturating match counter around seq_det_window.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = SEQ_MAX_LEN,
  parameter int                 CNT_W       = SEQ_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
  parameter int                 DEF_LEN     = SEQ_DEF_LEN,
  parameter logic               DEF_OVERLAP = SEQ_DEF_OVERLAP,
  localparam int                LEN_W       = len_w(MAX_LEN)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cfg_t             cfg_reg;
  logic             cfg_err_reg;
  logic             cfg_err_next;
  logic             y_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             step;
  logic             hit;

  // A load edge consumes the cycle, so x on that edge never enters the window.
  assign step         = en && !cfg_load && !cfg_err_reg;
  assign cfg_err_next = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .restart (cfg_load),
    .x       (x),
    .pattern (cfg_reg.pattern),
    .len     (cfg_reg.len),
    .overlap (cfg_reg.overlap),
    .hit     (hit)
  );

  // Clear takes priority over a coincident hit.
  always_comb begin
    count_next = count_reg;
    if (cnt_clr) begin
      count_next = '0;
    end else if (hit && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_reg     <= '{pattern: DEF_PATTERN, len: LEN_W'(DEF_LEN), overlap: DEF_OVERLAP};
      cfg_err_reg <= 1'b0;
      y_reg       <= 1'b0;
      count_reg   <= '0;
    end else begin
      if (cfg_load) begin
        cfg_reg     <= '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
        cfg_err_reg <= cfg_err_next;
      end
      y_reg     <= hit;
      count_reg <= count_next;
    end
  end

  assign y           = y_reg;
  assign match_count = count_reg;
  assign cfg_err     = cfg_err_reg;

endmodule
